pico_port_bank: RTL and testbench

- Parametrised PicoBlaze I/O port bank. It is the successor to the fixed two-register, one-strobe capture logic in the RTC top level.
- Decodes port_id/write_strobe into NUM_REGS configuration registers and a stretched command pulse.
- Provides a registered read-back mux to in_port, including a status register.
- Sits between the PicoBlaze core and the RTC control state machine.

---
 rtl/pico_port_pkg.sv | 20 ++
 rtl/pico_pulse_gen.sv | 52 +++++
 rtl/pico_port_bank.sv | 149 ++++++++++++++
 tb/tb_pico_port_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pico_port_pkg.sv
// Shared constants and types for the PicoBlaze port bank.
// The default addresses must match the firmware port header.
package pico_port_pkg;

  localparam int PORT_W = 8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;

  localparam logic [PORT_W-1:0] DEF_BASE_ADDR   = 8'h04;
  localparam logic [PORT_W-1:0] DEF_PULSE_ADDR  = 8'h01;
  localparam logic [PORT_W-1:0] DEF_STATUS_ADDR = 8'h0F;
  localparam logic [PORT_W-1:0] DEF_COMMIT_ADDR = 8'h0E;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/pico_pulse_gen.sv
// Command pulse generator: a trigger starts a pulse of exactly PULSE_LEN cycles.
// Triggers arriving while a pulse is running are dropped and reported on retrigger.
module pico_pulse_gen
  import pico_port_pkg::*;
#(
  parameter int PULSE_LEN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  output logic busy,
  output logic retrigger
);

  localparam logic [7:0] LOAD_VAL = 8'(PULSE_LEN - 1);

  pulse_state_t state, state_nxt;
  logic [7:0]   cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The final ACTIVE cycle (cnt==0) still counts as busy, so a trigger there is dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = (state == ACTIVE);
    retrigger = 1'b0;
    case (state)
      IDLE: begin
        if (fire) begin
          state_nxt = ACTIVE;
          cnt_nxt   = LOAD_VAL;
        end
      end
      ACTIVE: begin
        retrigger = fire;
        if (cnt == 8'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/pico_port_bank.sv
// PicoBlaze I/O port bank: configuration registers, command pulse and status read-back.
// Define SHADOW_COMMIT_EN to stage register writes in shadows applied by a commit-port write.
module pico_port_bank
  import pico_port_pkg::*;
#(
  parameter int                NUM_REGS    = 4,
  parameter int                DATA_W      = 8,
  parameter logic [PORT_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [PORT_W-1:0] PULSE_ADDR  = DEF_PULSE_ADDR,
  parameter logic [PORT_W-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter logic [PORT_W-1:0] COMMIT_ADDR = DEF_COMMIT_ADDR,
  parameter int                PULSE_LEN   = 1,
  parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PORT_W-1:0]          port_id,
  input  logic [PORT_W-1:0]          out_port,
  input  logic                       write_strobe,
  input  logic                       read_strobe,
  output logic [PORT_W-1:0]          in_port,
  output logic [NUM_REGS*DATA_W-1:0] cfg_q,
  output logic [NUM_REGS-1:0]        cfg_upd,
  output logic                       cmd_pulse,
  output logic                       cmd_busy
);

  localparam int BASE_I   = int'(BASE_ADDR);
  localparam int LAST_I   = BASE_I + NUM_REGS - 1;
  localparam int PULSE_I  = int'(PULSE_ADDR);
  localparam int STATUS_I = int'(STATUS_ADDR);
  localparam int COMMIT_I = int'(COMMIT_ADDR);

  localparam logic [PORT_W-1:0] NREGS_B = PORT_W'(NUM_REGS);

  // The address map is fixed at build time, so conflicts are rejected here rather than arbitrated.
  if (NUM_REGS < 1 || NUM_REGS > 16 || DATA_W < 1 || DATA_W > 8 ||
      PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_param
    $error("pico_port_bank: parameter out of legal range");
  end
  if (LAST_I > 255) begin : g_bad_window
    $error("pico_port_bank: register window runs past port 0xFF");
  end
  if ((PULSE_I >= BASE_I && PULSE_I <= LAST_I) ||
      (STATUS_I >= BASE_I && STATUS_I <= LAST_I) ||
      (COMMIT_I >= BASE_I && COMMIT_I <= LAST_I) ||
      PULSE_I == STATUS_I || PULSE_I == COMMIT_I || STATUS_I == COMMIT_I) begin : g_bad_map
    $error("pico_port_bank: overlapping port addresses");
  end

  logic [PORT_W-1:0]          idx;
  logic                       in_win;
  logic [NUM_REGS-1:0]        wr_mask;
  logic                       pulse_fire, retrigger, err;
  logic [NUM_REGS*DATA_W-1:0] cfg_r;
  logic [PORT_W-1:0]          status, rd_data;

  always_comb begin
    idx     = port_id - BASE_ADDR;
    in_win  = (port_id >= BASE_ADDR) && (idx < NREGS_B);
    wr_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_mask[i] = write_strobe && in_win && (idx == PORT_W'(i));
    end
  end

  assign pulse_fire = write_strobe && (port_id == PULSE_ADDR);

  pico_pulse_gen #(
    .PULSE_LEN (PULSE_LEN)
  ) u_pulse (
    .clk       (clk),
    .reset     (reset),
    .fire      (pulse_fire),
    .busy      (cmd_busy),
    .retrigger (retrigger)
  );

  assign cmd_pulse = cmd_busy;

`ifdef SHADOW_COMMIT_EN
  logic [NUM_REGS*DATA_W-1:0] shadow;
  logic [NUM_REGS-1:0]        dirty;
  logic                       commit;

  assign commit = write_strobe && (port_id == COMMIT_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_r   <= {NUM_REGS{RST_VAL}};
      shadow  <= {NUM_REGS{RST_VAL}};
      dirty   <= '0;
      cfg_upd <= '0;
    end else begin
      cfg_upd <= '0;
      dirty   <= dirty | wr_mask;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_mask[i]) shadow[i*DATA_W +: DATA_W] <= out_port[DATA_W-1:0];
      end
      if (commit) begin
        cfg_r   <= shadow;
        cfg_upd <= dirty;
        dirty   <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_r   <= {NUM_REGS{RST_VAL}};
      cfg_upd <= '0;
    end else begin
      cfg_upd <= wr_mask;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_mask[i]) cfg_r[i*DATA_W +: DATA_W] <= out_port[DATA_W-1:0];
      end
    end
  end
`endif

  assign cfg_q = cfg_r;

  // A retrigger in the same cycle as a status read leaves err set.
  always_ff @(posedge clk) begin
    if (!reset)                                          err <= 1'b0;
    else if (retrigger)                                  err <= 1'b1;
    else if (read_strobe && (port_id == STATUS_ADDR))    err <= 1'b0;
  end

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = cmd_busy;
    status[STAT_ERR]  = err;
    rd_data           = '0;
    if (in_win) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx == PORT_W'(i)) rd_data = PORT_W'(cfg_r[i*DATA_W +: DATA_W]);
      end
    end else if (port_id == STATUS_ADDR) begin
      rd_data = status;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) in_port <= '0;
    else        in_port <= rd_data;
  end

endmodule

// File: tb/tb_pico_port_bank.sv
// Self-checking bench for pico_port_bank (NUM_REGS=4, DATA_W=8, PULSE_LEN=3).
// Also covers the SHADOW_COMMIT_EN build when that macro is defined.
module tb_pico_port_bank;

  localparam int LEN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id, out_port, in_port;
  logic        write_strobe, read_strobe;
  logic [31:0] cfg_q;
  logic [3:0]  cfg_upd;
  logic        cmd_pulse, cmd_busy;

  int n_cmp = 0;
  int n_bad = 0;

  pico_port_bank #(
    .PULSE_LEN (LEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .cfg_q        (cfg_q),
    .cfg_upd      (cfg_upd),
    .cmd_pulse    (cmd_pulse),
    .cmd_busy     (cmd_busy)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, remaining pulse cycles and the sticky error.
  logic [7:0] m_cfg [4];
  logic [7:0] m_sh  [4];
  logic [3:0] m_dirty, m_upd;
  logic [7:0] m_in;
  int         m_rem;
  bit         m_err;

  task automatic modelStep(input bit rst, input logic [7:0] pid, input logic [7:0] data,
                           input bit ws, input bit rs);
    bit win, fire;
    int k;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin m_cfg[i] = 8'h00; m_sh[i] = 8'h00; end
      m_dirty = 4'h0; m_upd = 4'h0; m_in = 8'h00; m_rem = 0; m_err = 1'b0;
      return;
    end
    win  = (pid >= 8'h04) && (pid <= 8'h07);
    k    = int'(pid) - 4;
    fire = ws && (pid == 8'h01);
    if (win)               m_in = m_cfg[k];
    else if (pid == 8'h0F) m_in = {6'b0, m_err, (m_rem > 0)};
    else                   m_in = 8'h00;
    if (fire && m_rem > 0)          m_err = 1'b1;
    else if (rs && pid == 8'h0F)    m_err = 1'b0;
    if (m_rem > 0)   m_rem = m_rem - 1;
    else if (fire)   m_rem = LEN;
    m_upd = 4'h0;
`ifdef SHADOW_COMMIT_EN
    if (ws && win) begin m_sh[k] = data; m_dirty[k] = 1'b1; end
    if (ws && pid == 8'h0E) begin
      for (int i = 0; i < 4; i++) m_cfg[i] = m_sh[i];
      m_upd   = m_dirty;
      m_dirty = 4'h0;
    end
`else
    if (ws && win) begin m_cfg[k] = data; m_upd[k] = 1'b1; end
`endif
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic applyStimulus(input bit rst, input logic [7:0] pid, input logic [7:0] data,
                               input bit ws, input bit rs);
    reset        = rst;
    port_id      = pid;
    out_port     = data;
    write_strobe = ws;
    read_strobe  = rs;
    @(posedge clk);
    modelStep(rst, pid, data, ws, rs);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".cfg_q"},     cfg_q,     {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
    compare({tag, ".cfg_upd"},   {28'b0, cfg_upd},   {28'b0, m_upd});
    compare({tag, ".cmd_pulse"}, {31'b0, cmd_pulse}, {31'b0, m_rem > 0});
    compare({tag, ".cmd_busy"},  {31'b0, cmd_busy},  {31'b0, m_rem > 0});
    compare({tag, ".in_port"},   {24'b0, in_port},   {24'b0, m_in});
  endtask

  typedef struct {
    bit          rst;
    logic [7:0]  pid;
    logic [7:0]  data;
    bit          ws;
    bit          rs;
    logic [31:0] cfg;
    logic [3:0]  upd;
    bit          pulse;
    logic [7:0]  inp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int hi;
    bit done;
    logic [7:0] pid;
    int sel;

    reset = 1'b0; port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0;

`ifndef SHADOW_COMMIT_EN
    // rst pid data ws rs | cfg_q upd pulse in_port
    tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h04, 8'h00, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h06, 8'hA5, 1'b1, 1'b0, 32'h00A50000, 4'b0100, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h06, 8'h00, 1'b0, 1'b0, 32'h00A50000, 4'b0000, 1'b0, 8'hA5});
    tbl.push_back('{1'b1, 8'h20, 8'hFF, 1'b1, 1'b0, 32'h00A50000, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h04, 8'h3C, 1'b1, 1'b0, 32'h00A5003C, 4'b0001, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h04, 8'h00, 1'b0, 1'b0, 32'h00A5003C, 4'b0000, 1'b0, 8'h3C});
    tbl.push_back('{1'b1, 8'h08, 8'h77, 1'b1, 1'b0, 32'h00A5003C, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h03, 8'h55, 1'b1, 1'b0, 32'h00A5003C, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h07, 8'h99, 1'b1, 1'b0, 32'h99A5003C, 4'b1000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h07, 8'h00, 1'b0, 1'b0, 32'h99A5003C, 4'b0000, 1'b0, 8'h99});
    tbl.push_back('{1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 32'h99A5003C, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 32'h99A5003C, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 32'h99A5003C, 4'b0000, 1'b1, 8'h03});
    tbl.push_back('{1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 32'h99A5003C, 4'b0000, 1'b0, 8'h03});
    tbl.push_back('{1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 32'h99A5003C, 4'b0000, 1'b0, 8'h02});
    tbl.push_back('{1'b1, 8'h0F, 8'h00, 1'b0, 1'b1, 32'h99A5003C, 4'b0000, 1'b0, 8'h02});
    tbl.push_back('{1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 32'h99A5003C, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 32'h99A5003C, 4'b0000, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00});

    foreach (tbl[v]) begin
      applyStimulus(tbl[v].rst, tbl[v].pid, tbl[v].data, tbl[v].ws, tbl[v].rs);
      compare($sformatf("vec%0d.cfg_q", v),   cfg_q,                tbl[v].cfg);
      compare($sformatf("vec%0d.cfg_upd", v), {28'b0, cfg_upd},     {28'b0, tbl[v].upd});
      compare($sformatf("vec%0d.pulse", v),   {30'b0, cmd_pulse, cmd_busy},
                                              {30'b0, tbl[v].pulse, tbl[v].pulse});
      compare($sformatf("vec%0d.in_port", v), {24'b0, in_port},     {24'b0, tbl[v].inp});
    end
`else
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 8'h11, 1'b1, 1'b0);
    compare("sh_wr0.cfg_q", cfg_q, 32'h00000000);
    compare("sh_wr0.cfg_upd", {28'b0, cfg_upd}, 32'h0);
    applyStimulus(1'b1, 8'h07, 8'h22, 1'b1, 1'b0);
    compare("sh_wr3.cfg_q", cfg_q, 32'h00000000);
    compare("sh_wr3.cfg_upd", {28'b0, cfg_upd}, 32'h0);
    applyStimulus(1'b1, 8'h04, 8'h00, 1'b0, 1'b0);
    compare("sh_read_active", {24'b0, in_port}, 32'h00);
    applyStimulus(1'b1, 8'h0E, 8'h5A, 1'b1, 1'b0);
    compare("sh_commit.cfg_q", cfg_q, 32'h22000011);
    compare("sh_commit.cfg_upd", {28'b0, cfg_upd}, 32'h9);
    applyStimulus(1'b1, 8'h04, 8'h00, 1'b0, 1'b0);
    compare("sh_after.cfg_upd", {28'b0, cfg_upd}, 32'h0);
    compare("sh_after.in_port", {24'b0, in_port}, 32'h11);
    applyStimulus(1'b1, 8'h0E, 8'h00, 1'b1, 1'b0);
    compare("sh_empty_commit.cfg_upd", {28'b0, cfg_upd}, 32'h0);
    compare("sh_empty_commit.cfg_q", cfg_q, 32'h22000011);
`endif

    // Pulse length measured from the outside, bounded so a stuck pulse cannot hang the run.
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
    hi = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (cmd_pulse) begin
        hi++;
        applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL pulse_timeout: got cmd_pulse still high after 20 cycles, expected low");
    end
    compare("pulse_len", hi, LEN);

    // Trigger landing on the last pulse cycle must be dropped and flagged.
    applyStimulus(1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
    compare("edge_retrigger.pulse", {31'b0, cmd_pulse}, 32'h0);
    applyStimulus(1'b1, 8'h0F, 8'h00, 1'b0, 1'b1);
    compare("edge_retrigger.status", {24'b0, in_port}, 32'h02);
    checkOutput("edge_retrigger");
    applyStimulus(1'b1, 8'h0F, 8'h00, 1'b0, 1'b0);
    compare("status_cleared", {24'b0, in_port}, 32'h00);

    // Randomised traffic against the model, biased toward interesting ports.
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: pid = 8'h04 + 8'($urandom_range(0, 3));
        4:          pid = 8'h01;
        5:          pid = 8'h0F;
        6:          pid = 8'h0E;
        7:          pid = ($urandom_range(0, 1) != 0) ? 8'h03 : 8'h08;
        default:    pid = 8'($urandom);
      endcase
      applyStimulus($urandom_range(0, 59) != 0, pid, 8'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
